// File: rtl/rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin arbiter and its priority encoders.
package rr_arbiter_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int DEFAULT_N        = 16;
   localparam int DEFAULT_MAX_HOLD = 8;

   // Never returns less than one bit, so a two-entry vector still gets a usable index.
   function automatic int index_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter_priority_encoder.sv
// Lowest-index-wins priority encoder: reports the lowest set bit and whether any bit is set.
module priority_encoder
   import rr_arbiter_pkg::*;
#(
   parameter int ONEHOT_WIDTH = DEFAULT_N,
   parameter int BIN_WIDTH    = index_width(ONEHOT_WIDTH)
) (
   input  logic [ONEHOT_WIDTH-1:0] i_one_hot,
   output logic [BIN_WIDTH-1:0]    o_bin,
   output logic                    o_active
);

   // Scanning from the top down lets the lowest set bit overwrite any higher one.
   always_comb begin
      o_bin    = '0;
      o_active = |i_one_hot;
      for (int i = ONEHOT_WIDTH - 1; i >= 0; i--) begin
         if (i_one_hot[i]) begin
            o_bin = BIN_WIDTH'(i);
         end
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, a binary grant index and a
// hold timer that forces re-arbitration when a holder keeps the resource under contention.
module rr_arbiter
   import rr_arbiter_pkg::*;
#(
   parameter int N        = DEFAULT_N,
   parameter int W        = index_width(N),
   parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [N-1:0] i_req,
   output logic [N-1:0] o_grant,
   output logic [W-1:0] o_grant_bin,
   output logic         o_grant_valid
);

   localparam int              HW        = index_width(MAX_HOLD + 1);
   localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);
   localparam logic [N-1:0]    ONE_BIT   = N'(1);

   state_t         state, state_nxt;
   logic [N-1:0]   grant, grant_nxt;
   logic [W-1:0]   grant_bin, bin_nxt;
   logic [W-1:0]   ptr, ptr_nxt;
   logic [HW-1:0]  hold_cnt, hold_nxt;

   logic [N-1:0]   mask;
   logic [N-1:0]   masked_req;
   logic [W-1:0]   masked_bin, unmasked_bin, winner;
   logic           masked_active, any_req;
   logic           holder_req, others_req, take;

   // Requesters at or above the pointer get first pick; the rest wait for the wrap.
   always_comb begin
      mask = '0;
      for (int k = 0; k < N; k++) begin
         mask[k] = (k >= int'(ptr));
      end
   end

   assign masked_req = i_req & mask;

   priority_encoder #(.ONEHOT_WIDTH(N), .BIN_WIDTH(W)) u_masked_enc (
      .i_one_hot (masked_req),
      .o_bin     (masked_bin),
      .o_active  (masked_active)
   );

   priority_encoder #(.ONEHOT_WIDTH(N), .BIN_WIDTH(W)) u_unmasked_enc (
      .i_one_hot (i_req),
      .o_bin     (unmasked_bin),
      .o_active  (any_req)
   );

   assign winner     = masked_active ? masked_bin : unmasked_bin;
   assign holder_req = |(i_req & grant);
   assign others_req = |(i_req & ~grant);

   // A release takes precedence over a timeout; both re-arbitrate through the same path.
   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      bin_nxt   = grant_bin;
      ptr_nxt   = ptr;
      hold_nxt  = hold_cnt;
      take      = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               take = 1'b1;
            end
         end
         GRANT: begin
            if (!holder_req) begin
               if (any_req) begin
                  take = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  grant_nxt = '0;
                  bin_nxt   = '0;
                  hold_nxt  = '0;
               end
            end else if (others_req) begin
               if (hold_cnt == HOLD_LAST) begin
                  take = 1'b1;
               end else begin
                  hold_nxt = hold_cnt + 1'b1;
               end
            end else begin
               hold_nxt = '0;
            end
         end
      endcase
      if (take) begin
         state_nxt = GRANT;
         grant_nxt = ONE_BIT << winner;
         bin_nxt   = winner;
         ptr_nxt   = winner + 1'b1;
         hold_nxt  = '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= IDLE;
         grant     <= '0;
         grant_bin <= '0;
         ptr       <= '0;
         hold_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         grant     <= grant_nxt;
         grant_bin <= bin_nxt;
         ptr       <= ptr_nxt;
         hold_cnt  <= hold_nxt;
      end
   end

   assign o_grant       = grant;
   assign o_grant_bin   = grant_bin;
   assign o_grant_valid = (state == GRANT);

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter sharing one resource among N requesters; one grant at a time.
- Request vectors are resolved through priority_encoder instances into a registered one-hot grant plus binary index.
- A hold timer forces re-arbitration so a requester cannot starve the others.
- Sits between requester ports and the shared datapath; the grant index drives the datapath mux select.

Parameters:
- N, 16, number of requesters (power of two, 2..32).
- W, $clog2(N), width of binary grant index.
- MAX_HOLD, 8, maximum consecutive grant cycles while another request is pending (>=1).

Ports:
- i_clk  input  1  clock, all state on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_req  input  N  request vector; bit k held high while requester k wants or uses the resource.
- o_grant  output  N  registered one-hot grant; all zeros when idle.
- o_grant_bin  output  W  binary index of the granted requester; 0 when idle.
- o_grant_valid  output  1  high when o_grant is non-zero.

Behaviour:
- Reset (async assert, held while i_rst=1): o_grant=0, o_grant_bin=0, o_grant_valid=0, ptr=0, hold_cnt=0, state=IDLE. Reset mid-grant drops the grant immediately, with no completion.
- Selection rule:
  - masked = i_req with bits below ptr cleared; winner = lowest set index of masked.
  - If masked is empty, winner = lowest set index of i_req.
  - Implemented with two priority_encoder instances (masked, unmasked), using o_active to choose.
- State IDLE:
  - If i_req != 0 at an edge, go to GRANT with o_grant=onehot(winner), o_grant_bin=winner, ptr=(winner+1) mod N, hold_cnt=0.
  - Latency is 1 cycle from a sampled request to the grant.
- State GRANT (current index g):
  - Release: i_req[g]=0 at an edge.
    - If other requests are pending, grant the new winner on the same edge (no idle bubble) and reset hold_cnt.
    - Otherwise go to IDLE with outputs cleared.
  - Timeout: i_req[g]=1, hold_cnt==MAX_HOLD-1 and another bit of i_req set. Re-arbitrate to the winner (never g, because ptr=g+1) and reset hold_cnt.
  - Otherwise keep the grant.
    - hold_cnt increments while other requests are pending.
    - hold_cnt is cleared to 0 while g is the sole requester; an uncontended holder keeps the grant indefinitely.
- ptr wraps from N-1 to 0.
- Simultaneous events: release and timeout on the same edge are treated as release.
- New requests arriving on the release edge take part in that arbitration.
- o_grant is never combinationally dependent on i_req; all outputs are registered.
- Invariant: o_grant is zero or exactly one-hot; o_grant_bin matches o_grant; o_grant_valid == |o_grant.

Decomposition:
- Shared package holds:
  - state enum {IDLE, GRANT};
  - the index width function (clog2);
  - default N / MAX_HOLD constants.
- Sub-module: the existing priority_encoder (ONEHOT_WIDTH=N; ports i_one_hot, o_bin, o_active), instantiated twice.
- Mask generation, the hold counter and the FSM stay in rr_arbiter.

Test Plan:
- Reset then i_req=16'h0001: o_grant=16'h0001, o_grant_bin=0, valid=1 one cycle after the sampling edge. Drop i_req, then o_grant=0 next edge.
- Round robin: i_req=16'h0015 (bits 0,2,4), each requester drops its bit one cycle after its grant and re-raises it next cycle. Grant sequence 0,2,4,0,2,… with no idle cycles between grants.
- Timeout: hold i_req=16'h0003 constantly. Grant bin0 for 8 cycles, then bin1 for 8 cycles, alternating forever. Solo i_req=16'h0008 for 50 cycles keeps grant 3 throughout.
- Wrap: ptr=15 after granting 14. i_req=16'h4001 (bits 0,14) gives grant 0, then 14.
- Async reset asserted mid-grant, between clock edges: o_grant=0 and valid=0 immediately. After release with i_req=16'h0100, grant is 8 (ptr restarted at 0).
- Random: 1000 cycles of $random i_req with sticky hold. Checker verifies one-hot/bin/valid consistency, that no grant goes to a non-requesting bit after one cycle, and a bound of (N-1)*MAX_HOLD+N cycles from request to grant.
